// File: rtl/hdmi_video_framer_if.sv
// Pixel-domain video input bundle (RGB, syncs, data enable) feeding hdmi_video_framer.
interface hdmi_video_framer_if;
  logic [23:0] rgb_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        de_in;

  modport master (output rgb_in, hsync_in, vsync_in, de_in);
  modport slave  (input  rgb_in, hsync_in, vsync_in, de_in);
endinterface

// File: rtl/hdmi_video_framer.sv
// TMDS framer: delay line, DVI/HDMI preamble+guard sequencer, two-stage 8b/10b encoder.
// Optional colour-bar source is enabled by defining HDMI_TEST_PATTERN_EN.
module hdmi_video_framer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
`ifdef HDMI_TEST_PATTERN_EN
  , parameter int BAR_WIDTH  = 160
`endif
) (
  input  logic               clk,
  input  logic               rst,
  hdmi_video_framer_if.slave vid,
  input  logic               hdmi_mode,
  input  logic               err_clr,
`ifdef HDMI_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  output logic [29:0]        tmds_out,
  output logic               guard_err
);

  localparam int LEAD    = PREAMBLE_LEN + GUARD_LEN;
  localparam int CNT_MAX = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] GB_02 = 10'b1011001100;
  localparam logic [9:0] GB_1  = 10'b0100110011;

  typedef enum logic [1:0] {ST_CTRL, ST_PRE, ST_GUARD, ST_VIDEO} state_t;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] qm;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm       = 9'd0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8]    = ~use_xnor;
    return qm;
  endfunction

  // Returns {new_disparity[4:0], q[9:0]}; n1 is the ones count of qm[7:0].
  function automatic logic [14:0] tmds_word(input logic [8:0] qm, input logic [3:0] n1,
                                            input logic signed [4:0] rd);
    logic signed [4:0] diff;
    logic signed [4:0] rd_nx;
    logic [9:0]        q;
    diff = $signed({n1, 1'b0} - 5'd8);
    if ((rd == 5'sd0) || (diff == 5'sd0)) begin
      q     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      rd_nx = qm[8] ? (rd + diff) : (rd - diff);
    end else if (((rd > 5'sd0) && (diff > 5'sd0)) || ((rd < 5'sd0) && (diff < 5'sd0))) begin
      q     = {1'b1, qm[8], ~qm[7:0]};
      rd_nx = rd + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      q     = {1'b0, qm[8], qm[7:0]};
      rd_nx = rd - (qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
    return {rd_nx, q};
  endfunction

  function automatic logic [9:0] ctl_tok(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK00;
      2'b01:   t = TOK01;
      2'b10:   t = TOK10;
      2'b11:   t = TOK11;
      default: t = TOK00;
    endcase
    return t;
  endfunction

  logic [26:0]       dl [LEAD];
  logic [26:0]       dly;
  logic              dly_de;
  logic              de_rise;
  logic [23:0]       rgb_src;
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              enter_err;
  logic [8:0]        qm_c  [3];
  logic [8:0]        s1_qm [3];
  logic [3:0]        s1_n1 [3];
  logic [1:0]        s1_sync;
  logic [14:0]       enc_w [3];
  logic signed [4:0] disp    [3];
  logic signed [4:0] disp_nx [3];
  logic [29:0]       tmds_nx;

  assign dly     = dl[LEAD-1];
  assign dly_de  = dly[26];
  assign de_rise = vid.de_in & ~dl[0][26];

`ifdef HDMI_TEST_PATTERN_EN
  localparam int POS_W = $clog2(BAR_WIDTH + 1);
  logic [POS_W-1:0] bar_pos, pos_eff;
  logic [2:0]       bar_idx, idx_eff;
  logic [23:0]      bar_rgb;

  // Position within the current bar; a rising de restarts the line at bar 0.
  always_comb begin
    pos_eff = de_rise ? '0 : bar_pos;
    idx_eff = de_rise ? 3'd0 : bar_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_pos <= '0;
      bar_idx <= 3'd0;
    end else if (vid.de_in) begin
      if (pos_eff == POS_W'(BAR_WIDTH - 1)) begin
        bar_pos <= '0;
        bar_idx <= (idx_eff == 3'd7) ? 3'd7 : (idx_eff + 3'd1);
      end else begin
        bar_pos <= pos_eff + POS_W'(1);
        bar_idx <= idx_eff;
      end
    end
  end

  always_comb begin
    case (idx_eff)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    rgb_src = pattern_sel ? bar_rgb : vid.rgb_in;
  end
`else
  assign rgb_src = vid.rgb_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEAD; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {vid.de_in, vid.vsync_in, vid.hsync_in, rgb_src};
      for (int i = 1; i < LEAD; i++) dl[i] <= dl[i-1];
    end
  end

  // The state register is aligned with encoder stage 1, so PRE+GUARD (LEAD cycles)
  // started at the undelayed de rise end exactly when the delayed line begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CTRL;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    enter_err = 1'b0;
    case (state)
      ST_CTRL: begin
        if (de_rise && hdmi_mode) begin
          state_nx = ST_PRE;
          cnt_nx   = CNT_W'(PREAMBLE_LEN);
        end else if (dly_de) begin
          state_nx  = ST_VIDEO;
          enter_err = hdmi_mode;
        end else begin
          state_nx = ST_CTRL;
        end
      end
      ST_PRE: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_GUARD;
          cnt_nx   = CNT_W'(GUARD_LEN);
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_GUARD: begin
        if (cnt == CNT_W'(1)) begin
          state_nx = ST_VIDEO;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_VIDEO: begin
        if (!dly_de) state_nx = ST_CTRL;
        else         state_nx = ST_VIDEO;
      end
      default: begin
        state_nx = ST_CTRL;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    for (int c = 0; c < 3; c++) qm_c[c] = tmds_qm(dly[8*c +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sync <= 2'b00;
      for (int c = 0; c < 3; c++) begin
        s1_qm[c] <= '0;
        s1_n1[c] <= '0;
      end
    end else begin
      s1_sync <= dly[25:24];
      for (int c = 0; c < 3; c++) begin
        s1_qm[c] <= qm_c[c];
        s1_n1[c] <= ones8(qm_c[c][7:0]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) enc_w[c] = tmds_word(s1_qm[c], s1_n1[c], disp[c]);
  end

  // Symbol selection; disparity only survives across consecutive VIDEO cycles.
  always_comb begin
    tmds_nx = {TOK00, TOK00, TOK00};
    for (int c = 0; c < 3; c++) disp_nx[c] = 5'sd0;
    case (state)
      ST_CTRL:  tmds_nx = {TOK00, TOK00, ctl_tok(s1_sync)};
      ST_PRE:   tmds_nx = {TOK00, TOK01, ctl_tok(s1_sync)};
      ST_GUARD: tmds_nx = {GB_02, GB_1, GB_02};
      ST_VIDEO: begin
        for (int c = 0; c < 3; c++) begin
          tmds_nx[10*c +: 10] = enc_w[c][9:0];
          disp_nx[c]          = $signed(enc_w[c][14:10]);
        end
      end
      default:  tmds_nx = {TOK00, TOK00, TOK00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmds_out <= {TOK00, TOK00, TOK00};
      for (int c = 0; c < 3; c++) disp[c] <= 5'sd0;
    end else begin
      tmds_out <= tmds_nx;
      for (int c = 0; c < 3; c++) disp[c] <= disp_nx[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            guard_err <= 1'b0;
    else if (enter_err) guard_err <= 1'b1;
    else if (err_clr)   guard_err <= 1'b0;
    else                guard_err <= guard_err;
  end

endmodule

// File: tb/tb_hdmi_video_framer.sv
// Directed bench for hdmi_video_framer: reset, DVI latency, HDMI framing, short blank,
// reset mid-preamble, and (with HDMI_TEST_PATTERN_EN) colour bars.
`timescale 1ns/1ps
module tb_hdmi_video_framer;
  localparam logic [9:0]  T00   = 10'b1101010100;
  localparam logic [9:0]  T01   = 10'b0010101011;
  localparam logic [9:0]  GB0   = 10'b1011001100;
  localparam logic [9:0]  GB1   = 10'b0100110011;
  localparam logic [29:0] W_RST = {T00, T00, T00};
  localparam logic [29:0] W_CH1 = {T00, T00, T01};
  localparam logic [29:0] W_PRE = {T00, T01, T01};
  localparam logic [29:0] W_GB  = {GB0, GB1, GB0};
  localparam logic [29:0] W_Z0  = {10'h100, 10'h100, 10'h100};
  localparam logic [29:0] W_Z1  = {10'h3FF, 10'h3FF, 10'h3FF};

  logic        clk = 1'b0;
  logic        rst, hdmi_mode, err_clr;
  logic [29:0] tmds_out;
  logic        guard_err;
  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          guard_hits;
`ifdef HDMI_TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  hdmi_video_framer_if vif();

  hdmi_video_framer #(
    .PREAMBLE_LEN(8),
    .GUARD_LEN(2)
`ifdef HDMI_TEST_PATTERN_EN
    , .BAR_WIDTH(4)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vif),
    .hdmi_mode(hdmi_mode),
    .err_clr(err_clr),
`ifdef HDMI_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .tmds_out(tmds_out),
    .guard_err(guard_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_scan();
    tick();
    if (tmds_out[9:0] == GB0 || tmds_out[19:10] == GB1 || tmds_out[29:20] == GB0) guard_hits++;
  endtask

  // Raises de and checks the 1 ctrl + 8 preamble + 2 guard + 2 video words (hsync=1, vsync=0).
  task automatic hdmi_line(input string tag, input logic [23:0] rgb,
                           input logic [29:0] v0, input logic [29:0] v1);
    vif.de_in  = 1'b1;
    vif.rgb_in = rgb;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1)       check_vec({tag, "_ctrl"}, 32'(tmds_out), 32'(W_CH1));
      else if (t <= 9)  check_vec({tag, "_pre"},  32'(tmds_out), 32'(W_PRE));
      else if (t <= 11) check_vec({tag, "_gb"},   32'(tmds_out), 32'(W_GB));
      else if (t == 12) check_vec({tag, "_v0"},   32'(tmds_out), 32'(v0));
      else              check_vec({tag, "_v1"},   32'(tmds_out), 32'(v1));
    end
  endtask

`ifdef HDMI_TEST_PATTERN_EN
  task automatic ref_enc(input logic [7:0] d, inout int rd, output logic [9:0] q);
    logic [8:0] m;
    logic       inv;
    int         k, bal;
    inv  = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
    m    = 9'd0;
    m[0] = d[0];
    for (int i = 1; i < 8; i++) m[i] = inv ? (m[i-1] ~^ d[i]) : (m[i-1] ^ d[i]);
    m[8] = ~inv;
    k    = $countones(m[7:0]);
    bal  = k - (8 - k);
    if (rd == 0 || bal == 0) begin
      q  = {~m[8], m[8], (m[8] ? m[7:0] : ~m[7:0])};
      rd = rd + (m[8] ? bal : -bal);
    end else if ((rd > 0 && bal > 0) || (rd < 0 && bal < 0)) begin
      q  = {1'b1, m[8], ~m[7:0]};
      rd = rd + (m[8] ? 2 : 0) - bal;
    end else begin
      q  = {1'b0, m[8], m[7:0]};
      rd = rd - (m[8] ? 0 : 2) + bal;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; hdmi_mode = 1'b0; err_clr = 1'b0;
    vif.de_in = 1'b0; vif.rgb_in = 24'h000000; vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
`ifdef HDMI_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    repeat (3) tick();
    check_vec("rst_tmds", 32'(tmds_out), 32'(W_RST));
    check_vec("rst_err", 32'(guard_err), 32'd0);
    rst = 1'b0;

    // DVI: first video word exactly 12 clocks after de rises
    guard_hits = 0;
    repeat (20) tick_scan();
    check_vec("dvi_blank", 32'(tmds_out), 32'(W_RST));
    vif.de_in = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick_scan();
      if (t == 11)      check_vec("dvi_pre_lat", 32'(tmds_out), 32'(W_RST));
      else if (t == 12) check_vec("dvi_v0", 32'(tmds_out), 32'(W_Z0));
      else if (t == 13) check_vec("dvi_v1", 32'(tmds_out), 32'(W_Z1));
    end
    repeat (7) tick_scan();
    vif.de_in = 1'b0;
    repeat (30) tick_scan();
    check_vec("dvi_no_guard", 32'(guard_hits), 32'd0);
    check_vec("dvi_err", 32'(guard_err), 32'd0);

    // HDMI line with preamble and guard band
    hdmi_mode = 1'b1;
    vif.hsync_in = 1'b1;
    repeat (30) tick();
    hdmi_line("hdmi", 24'hFF1000, {10'h200, 10'h1F0, 10'h100}, {10'h0FF, 10'h1F0, 10'h3FF});
    check_vec("hdmi_err", 32'(guard_err), 32'd0);
    repeat (7) tick();

    // Short blank: next line enters video directly and flags the violation
    vif.de_in = 1'b0;
    repeat (5) tick();
    vif.de_in  = 1'b1;
    vif.rgb_in = 24'h000000;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 7)       check_vec("short_ctrl", 32'(tmds_out), 32'(W_CH1));
      else if (t == 10) check_vec("short_err_pre", 32'(guard_err), 32'd0);
      else if (t == 11) check_vec("short_err_set", 32'(guard_err), 32'd1);
      else if (t == 12) check_vec("short_v0", 32'(tmds_out), 32'(W_Z0));
    end
    repeat (8) tick();
    vif.de_in = 1'b0;
    repeat (20) tick();
    check_vec("err_sticky", 32'(guard_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_vec("err_clr", 32'(guard_err), 32'd0);
    repeat (10) tick();

    // Reset during the preamble aborts the sequence
    vif.de_in = 1'b1;
    repeat (4) tick();
    check_vec("pre_before_rst", 32'(tmds_out), 32'(W_PRE));
    rst = 1'b1;
    vif.de_in = 1'b0;
    tick();
    check_vec("rst_mid_pre", 32'(tmds_out), 32'(W_RST));
    rst = 1'b0;
    tick();
    check_vec("post_rst_ctrl", 32'(tmds_out), 32'(W_RST));
    repeat (30) tick();
    hdmi_line("rehdmi", 24'h000000, W_Z0, W_Z1);
    check_vec("rehdmi_err", 32'(guard_err), 32'd0);
    vif.de_in = 1'b0;
    repeat (20) tick();

`ifdef HDMI_TEST_PATTERN_EN
    begin
      logic [23:0] bars [8];
      logic [9:0]  q;
      logic [29:0] w;
      int          rd [3];
      int          bi;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      for (int c = 0; c < 3; c++) rd[c] = 0;
      hdmi_mode   = 1'b0;
      pattern_sel = 1'b1;
      vif.rgb_in  = 24'h123456;
      vif.de_in   = 1'b1;
      for (int t = 1; t <= 51; t++) begin
        tick();
        if (t == 40) vif.de_in = 1'b0;
        if (t >= 12) begin
          bi = ((t - 12) / 4 > 7) ? 7 : (t - 12) / 4;
          for (int c = 0; c < 3; c++) begin
            ref_enc(bars[bi][8*c +: 8], rd[c], q);
            w[10*c +: 10] = q;
          end
          check_vec("bar_pix", 32'(tmds_out), 32'(w));
        end
      end
      pattern_sel = 1'b0;
      repeat (20) tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
